control_unit: RTL and testbench



---
 rtl/control_unit_pkg.sv | 38 +++
 rtl/alu8.sv | 34 +++
 rtl/control_unit.sv | 170 +++++++++++++++++
 tb/tb_control_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared definitions for the 8-bit CPU: instruction field widths, opcode
// encodings and the sequencer state encoding. Imported by control_unit and alu8.
package control_unit_pkg;

    localparam int OPC_W  = 4;
    localparam int REG_W  = 2;
    localparam int DATA_W = 8;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP   = 4'h0,
        OP_LDI   = 4'h1,
        OP_MOV   = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_XOR   = 4'h7,
        OP_NOT   = 4'h8,
        OP_LD    = 4'h9,
        OP_ST    = 4'hA,
        OP_JMP   = 4'hB,
        OP_JZ    = 4'hC,
        OP_RSV_D = 4'hD,
        OP_RSV_E = 4'hE,
        OP_HALT  = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_LATCH,
        S_EXEC,
        S_IMM,
        S_MEMRD,
        S_WB,
        S_HALT
    } state_e;

endpackage

// File: rtl/alu8.sv
// alu8: purely combinational 8-bit ALU shared by the multi-cycle sequencer and
// the future pipelined core.
//   op_i   : instruction opcode (only MOV..NOT produce a result, others give 0)
//   a_i    : first operand (rd value)
//   b_i    : second operand (rs value)
//   y_o    : result, modulo 256
//   zero_o : high when y_o == 0
import control_unit_pkg::*;

module alu8 (
    input  logic [OPC_W-1:0]  op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o,
    output logic              zero_o
);

    always_comb begin
        y_o = '0;
        case (opcode_e'(op_i))
            OP_MOV:  y_o = b_i;
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_NOT:  y_o = ~b_i;
            default: y_o = '0;
        endcase
    end

    assign zero_o = (y_o == '0);

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer for the 8-bit CPU.
// Owns PC, instruction register, result register and zero flag, and drives the
// unified instruction/data memory and the 4x8 register file.
//   clk, rst          : clock, asynchronous active-high reset
//   mem_addr/mem_wdata/mem_we/mem_rdata : memory port (synchronous read)
//   readreg1/readreg2 : register file read selects (ir rd / ir rs)
//   read1/read2       : register file read data
//   writereg/regwrite/reg_wdata : register file write port (always from res)
//   pc_out            : current PC for debug
//   halted            : high while stopped on HALT
import control_unit_pkg::*;

module control_unit #(
    parameter logic [DATA_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    output logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [REG_W-1:0]  readreg1,
    output logic [REG_W-1:0]  readreg2,
    input  logic [DATA_W-1:0] read1,
    input  logic [DATA_W-1:0] read2,
    output logic [REG_W-1:0]  writereg,
    output logic              regwrite,
    output logic [DATA_W-1:0] reg_wdata,
    output logic [DATA_W-1:0] pc_out,
    output logic              halted
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              z_q, z_d;

    logic [DATA_W-1:0] alu_y;
    logic              alu_zero;
    opcode_e           opc;

    assign opc = opcode_e'(ir_q[7:4]);

    alu8 u_alu (
        .op_i   (ir_q[7:4]),
        .a_i    (read1),
        .b_i    (read2),
        .y_o    (alu_y),
        .zero_o (alu_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            res_q   <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            res_q   <= res_d;
            z_q     <= z_d;
        end
    end

    // Strobes depend only on state_q/ir_q, so they cannot glitch between edges.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        res_d     = res_q;
        z_d       = z_q;
        mem_addr  = pc_q;
        mem_wdata = '0;
        mem_we    = 1'b0;

        case (state_q)
            S_FETCH: begin
                state_d = S_LATCH;
            end

            S_LATCH: begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + 8'd1;
                state_d = S_EXEC;
            end

            S_EXEC: begin
                case (opc)
                    OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                        res_d   = alu_y;
                        z_d     = alu_zero;
                        state_d = S_WB;
                    end
                    // Immediate byte sits at pc; its read data arrives in S_IMM.
                    OP_LDI, OP_JMP, OP_JZ: begin
                        state_d = S_IMM;
                    end
                    OP_LD: begin
                        mem_addr = read2;
                        state_d  = S_MEMRD;
                    end
                    OP_ST: begin
                        mem_addr  = read2;
                        mem_wdata = read1;
                        mem_we    = 1'b1;
                        state_d   = S_FETCH;
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                    end
                    default: begin
                        state_d = S_FETCH;
                    end
                endcase
            end

            S_IMM: begin
                pc_d    = pc_q + 8'd1;
                state_d = S_FETCH;
                case (opc)
                    OP_LDI: begin
                        res_d   = mem_rdata;
                        state_d = S_WB;
                    end
                    OP_JMP: begin
                        pc_d = mem_rdata;
                    end
                    OP_JZ: begin
                        if (z_q) begin
                            pc_d = mem_rdata;
                        end
                    end
                    default: begin
                        state_d = S_FETCH;
                    end
                endcase
            end

            S_MEMRD: begin
                res_d   = mem_rdata;
                state_d = S_WB;
            end

            S_WB: begin
                state_d = S_FETCH;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign readreg1  = ir_q[3:2];
    assign readreg2  = ir_q[1:0];
    assign writereg  = ir_q[3:2];
    assign regwrite  = (state_q == S_WB);
    assign reg_wdata = res_q;
    assign pc_out    = pc_q;
    assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [1:0] readreg1;
    logic [1:0] readreg2;
    logic [7:0] read1;
    logic [7:0] read2;
    logic [1:0] writereg;
    logic       regwrite;
    logic [7:0] reg_wdata;
    logic [7:0] pc_out;
    logic       halted;

    int checks = 0;
    int errors = 0;

    // Environment: memory and register file, reloaded from images on 'load'.
    logic [7:0] mem     [256];
    logic [7:0] rf      [4];
    logic [7:0] mem_img [256];
    logic [7:0] rf_img  [4];
    logic       load;

    // ISA-level reference state.
    logic [7:0] m_mem [256];
    logic [7:0] m_rf  [4];
    logic [7:0] m_pc;
    logic       m_z;

    control_unit #(.RESET_PC(8'h10)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .readreg1  (readreg1),
        .readreg2  (readreg2),
        .read1     (read1),
        .read2     (read2),
        .writereg  (writereg),
        .regwrite  (regwrite),
        .reg_wdata (reg_wdata),
        .pc_out    (pc_out),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign read1 = rf[readreg1];
    assign read2 = rf[readreg2];

    always @(posedge clk) begin
        if (load) begin
            mem <= mem_img;
            rf  <= rf_img;
        end else begin
            if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
            if (regwrite === 1'b1) rf[writereg] <= reg_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic clear_images();
        for (int i = 0; i < 256; i++) mem_img[i] = 8'h00;
        for (int i = 0; i < 4; i++) rf_img[i] = 8'h00;
    endtask

    // Leaves the bench at a negedge with the DUT in its first fetch cycle.
    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b1;
        @(posedge clk);
        @(posedge clk);
        load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_mem = mem_img;
        m_rf  = rf_img;
        m_pc  = 8'h10;
        m_z   = 1'b0;
    endtask

    // Execute one instruction at ISA level; returns cycle cost and side effects.
    task automatic model_step(output int cyc, output bit wv, output logic [1:0] wr,
                              output logic [7:0] wval, output bit sv,
                              output logic [7:0] sa, output logic [7:0] sval,
                              output bit hv);
        logic [7:0] ins, pc1, a, b, v;
        logic [1:0] rd, rs;
        ins = m_mem[m_pc];
        rd  = ins[3:2];
        rs  = ins[1:0];
        pc1 = m_pc + 8'd1;
        a   = m_rf[rd];
        b   = m_rf[rs];
        wv = 0; sv = 0; hv = 0; wr = rd; wval = 0; sa = 0; sval = 0;
        cyc = 3;
        m_pc = pc1;
        case (int'(ins[7:4]))
            1: begin
                wv = 1; wval = m_mem[pc1]; cyc = 5; m_pc = pc1 + 8'd1;
            end
            2, 3, 4, 5, 6, 7, 8: begin
                case (int'(ins[7:4]))
                    2: v = b;
                    3: v = 8'((int'(a) + int'(b)) % 256);
                    4: v = 8'((int'(a) - int'(b) + 256) % 256);
                    5: v = a & b;
                    6: v = a | b;
                    7: v = a ^ b;
                    default: v = 8'(255 - int'(b));
                endcase
                wv = 1; wval = v; m_z = (v == 8'd0); cyc = 4;
            end
            9: begin
                wv = 1; wval = m_mem[b]; cyc = 5;
            end
            10: begin
                sv = 1; sa = b; sval = a; m_mem[b] = a;
            end
            11: begin
                m_pc = m_mem[pc1]; cyc = 4;
            end
            12: begin
                m_pc = m_z ? m_mem[pc1] : pc1 + 8'd1; cyc = 4;
            end
            15: begin
                hv = 1;
            end
            default: ;
        endcase
        if (wv) m_rf[rd] = wval;
    endtask

    task automatic exec_check(input string tag);
        int cyc, nw, ns, wcyc, scyc, early_halt;
        bit wv, sv, hv;
        logic [1:0] wr, gwr;
        logic [7:0] wval, sa, sval, gwv, gsa, gsv, exp_pc;
        exp_pc = m_pc;
        checks++;
        if (mem_addr !== exp_pc || pc_out !== exp_pc) begin
            errors++;
            $display("FAIL %s fetch_addr: mem_addr=%h pc_out=%h expected %h", tag, mem_addr, pc_out, exp_pc);
        end
        model_step(cyc, wv, wr, wval, sv, sa, sval, hv);
        nw = 0; ns = 0; wcyc = -1; scyc = -1; early_halt = 0;
        gwr = 0; gwv = 0; gsa = 0; gsv = 0;
        for (int i = 0; i < cyc; i++) begin
            if (regwrite !== 1'b0) begin nw++; wcyc = i; gwr = writereg; gwv = reg_wdata; end
            if (mem_we !== 1'b0) begin ns++; scyc = i; gsa = mem_addr; gsv = mem_wdata; end
            if (halted !== 1'b0) early_halt++;
            @(negedge clk);
        end
        checks++;
        if (nw != (wv ? 1 : 0) || (wv && (wcyc != cyc - 1 || gwr !== wr || gwv !== wval))) begin
            errors++;
            $display("FAIL %s regwrite: count=%0d cyc=%0d reg=%0d data=%h expected count=%0d cyc=%0d reg=%0d data=%h",
                     tag, nw, wcyc, gwr, gwv, wv ? 1 : 0, cyc - 1, wr, wval);
        end
        checks++;
        if (ns != (sv ? 1 : 0) || (sv && (scyc != 2 || gsa !== sa || gsv !== sval))) begin
            errors++;
            $display("FAIL %s store: count=%0d cyc=%0d addr=%h data=%h expected count=%0d cyc=2 addr=%h data=%h",
                     tag, ns, scyc, gsa, gsv, sv ? 1 : 0, sa, sval);
        end
        checks++;
        if (early_halt != 0) begin
            errors++;
            $display("FAIL %s halted_early: halted high %0d cycles, expected 0", tag, early_halt);
        end
        if (hv) begin
            nw = 0; ns = 0; early_halt = 0;
            for (int i = 0; i < 8; i++) begin
                if (halted !== 1'b1) early_halt++;
                if (regwrite !== 1'b0) nw++;
                if (mem_we !== 1'b0) ns++;
                @(negedge clk);
            end
            checks++;
            if (early_halt != 0 || nw != 0 || ns != 0) begin
                errors++;
                $display("FAIL %s halt_hold: low_cycles=%0d regwrites=%0d stores=%0d expected 0 0 0",
                         tag, early_halt, nw, ns);
            end
        end
    endtask

    task automatic test_reset();
        clear_images();
        do_reset();
        checks++;
        if (mem_addr !== 8'h10 || mem_we !== 1'b0 || regwrite !== 1'b0 ||
            reg_wdata !== 8'h00 || halted !== 1'b0 || pc_out !== 8'h10) begin
            errors++;
            $display("FAIL reset_values: addr=%h we=%b rw=%b wdata=%h halted=%b pc=%h expected 10 0 0 00 0 10",
                     mem_addr, mem_we, regwrite, reg_wdata, halted, pc_out);
        end
        for (int i = 0; i < 5; i++) exec_check("nop");
        exec_check("nop_end");
    endtask

    task automatic test_ldi_add_jz();
        clear_images();
        mem_img[8'h10] = 8'h14; mem_img[8'h11] = 8'h05;
        mem_img[8'h12] = 8'h18; mem_img[8'h13] = 8'hFB;
        mem_img[8'h14] = 8'h36;
        mem_img[8'h15] = 8'hC0; mem_img[8'h16] = 8'h40;
        do_reset();
        exec_check("ldi_r1");
        exec_check("ldi_r2");
        exec_check("add_zero");
        exec_check("jz_taken");
        exec_check("at_40");
        clear_images();
        mem_img[8'h10] = 8'h14; mem_img[8'h11] = 8'h01;
        mem_img[8'h12] = 8'h35;
        mem_img[8'h13] = 8'hC0; mem_img[8'h14] = 8'h40;
        do_reset();
        exec_check("ldi_one");
        exec_check("add_nonzero");
        exec_check("jz_not_taken");
        exec_check("at_15");
    endtask

    task automatic test_st_ld();
        clear_images();
        rf_img[3] = 8'h80; rf_img[1] = 8'hA5;
        mem_img[8'h10] = 8'hA7;
        mem_img[8'h11] = 8'h93;
        do_reset();
        exec_check("st");
        exec_check("ld");
        exec_check("after_ld");
    endtask

    task automatic test_reset_mid();
        clear_images();
        mem_img[8'h10] = 8'h14; mem_img[8'h11] = 8'h05;
        mem_img[8'h12] = 8'h35;
        do_reset();
        exec_check("mid_ldi");
        repeat (3) @(negedge clk);
        checks++;
        if (regwrite !== 1'b1 || reg_wdata !== 8'h0A) begin
            errors++;
            $display("FAIL mid_wb_reached: regwrite=%b data=%h expected 1 0a", regwrite, reg_wdata);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (regwrite !== 1'b0 || mem_we !== 1'b0 || pc_out !== 8'h10 || mem_addr !== 8'h10) begin
            errors++;
            $display("FAIL mid_reset_abort: regwrite=%b mem_we=%b pc=%h addr=%h expected 0 0 10 10",
                     regwrite, mem_we, pc_out, mem_addr);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rf[1] !== 8'h05) begin
            errors++;
            $display("FAIL mid_reset_reg: r1=%h expected 05", rf[1]);
        end
        rst = 1'b0;
    endtask

    task automatic test_halt_wrap();
        clear_images();
        mem_img[8'h10] = 8'hB0; mem_img[8'h11] = 8'hFF;
        mem_img[8'hFF] = 8'hF0;
        do_reset();
        exec_check("jmp_ff");
        exec_check("halt");
        clear_images();
        mem_img[8'h10] = 8'hB0; mem_img[8'h11] = 8'hFE;
        mem_img[8'hFE] = 8'h10; mem_img[8'hFF] = 8'h3C;
        do_reset();
        exec_check("jmp_fe");
        exec_check("ldi_wrap");
        exec_check("at_00");
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 256; i++) begin
                logic [3:0] op;
                logic [3:0] lo;
                op = 4'($urandom_range(0, 14));
                lo = 4'($urandom);
                mem_img[i] = {op, lo};
            end
            for (int i = 0; i < 4; i++) rf_img[i] = 8'($urandom);
            do_reset();
            for (int n = 0; n < 30; n++) exec_check("random");
        end
    endtask

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        test_reset();
        test_ldi_add_jz();
        test_st_ld();
        test_reset_mid();
        test_halt_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
